beq_datapath: RTL and testbench

- Single-cycle MIPS beq datapath slice: a 32x32 register file (RegFile_32_32 function) feeding a 32-bit ALU (ALU_32 function), plus a branch-target adder.
- Reads rs/rt from the instruction, compares them in the ALU and computes pc + 4 + (sign-extended immediate << 2).
- Sits between instruction fetch (supplies instruction and pc) and the PC-select logic (consumes branch_target and branch_taken).

---
 rtl/beq_datapath.sv | 112 +++++++++++
 tb/tb_beq_datapath.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/beq_datapath.sv
// Single-cycle MIPS beq datapath slice: 32x32 register file with combinational reads,
// a 32-bit ALU, a branch-target adder and the beq decision. Only N = 32 is supported.
module beq_datapath #(
    parameter int N    = 32,
    parameter int NREG = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  instruction,
    input  logic [31:0]  pc,
    input  logic [3:0]   ALU_OP,
    input  logic         RegWrite,
    input  logic [4:0]   wr_reg,
    input  logic [31:0]  wr_data,
    output logic [31:0]  rd_data1,
    output logic [31:0]  rd_data2,
    output logic [31:0]  alu_result,
    output logic         cout,
    output logic         slt,
    output logic         overflow,
    output logic         zero_flag,
    output logic [31:0]  branch_target,
    output logic         branch_taken
);
    localparam logic [5:0] OPC_BEQ = 6'b000100;
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    logic [4:0]   rs, rt;
    logic [5:0]   opcode;
    logic [15:0]  imm16;

    assign opcode = instruction[31:26];
    assign rs     = instruction[25:21];
    assign rt     = instruction[20:16];
    assign imm16  = instruction[15:0];

    // Register file
    logic [N-1:0] regs_q [NREG];
    logic [N-1:0] regs_d [NREG];

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign regs_d[gi] = '0;
            end else begin : g_rw
                assign regs_d[gi] = (RegWrite && (wr_reg == 5'(gi))) ? wr_data : regs_q[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (rst) regs_q[i] <= '0;
            else     regs_q[i] <= regs_d[i];
        end
    end

    // r0 is forced on read so it is 0 even before the first reset.
    assign rd_data1 = (rs == 5'd0) ? '0 : regs_q[rs];
    assign rd_data2 = (rt == 5'd0) ? '0 : regs_q[rt];

    // ALU
    logic [N:0] add_sum, sub_sum;
    logic       add_ovf, sub_ovf;

    assign add_sum = {1'b0, rd_data1} + {1'b0, rd_data2};
    assign sub_sum = {1'b0, rd_data1} + {1'b0, ~rd_data2} + {{N{1'b0}}, 1'b1};
    assign add_ovf = (rd_data1[N-1] == rd_data2[N-1]) && (add_sum[N-1] != rd_data1[N-1]);
    assign sub_ovf = (rd_data1[N-1] != rd_data2[N-1]) && (sub_sum[N-1] != rd_data1[N-1]);
    // Sign of the difference corrected by overflow gives the true signed compare.
    assign slt     = sub_sum[N-1] ^ sub_ovf;

    always_comb begin
        alu_result = '0;
        cout       = 1'b0;
        overflow   = 1'b0;
        case (ALU_OP)
            OP_AND: alu_result = rd_data1 & rd_data2;
            OP_OR:  alu_result = rd_data1 | rd_data2;
            OP_NOR: alu_result = ~(rd_data1 | rd_data2);
            OP_ADD: begin
                alu_result = add_sum[N-1:0];
                cout       = add_sum[N];
                overflow   = add_ovf;
            end
            OP_SUB: begin
                alu_result = sub_sum[N-1:0];
                cout       = sub_sum[N];
                overflow   = sub_ovf;
            end
            OP_SLT: begin
                alu_result = {{(N-1){1'b0}}, slt};
                cout       = sub_sum[N];
                overflow   = sub_ovf;
            end
            default: ;
        endcase
    end

    assign zero_flag = (alu_result == '0);

    // Branch target and decision
    assign branch_target = pc + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
    assign branch_taken  = zero_flag && (opcode == OPC_BEQ) && (ALU_OP == OP_SUB);

endmodule

// File: tb/tb_beq_datapath.sv
// Directed self-checking bench for beq_datapath; each task checks one feature inline.
module tb_beq_datapath;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [3:0]  ALU_OP;
    logic        RegWrite;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic [31:0] rd_data1, rd_data2, alu_result, branch_target;
    logic        cout, slt, overflow, zero_flag, branch_taken;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    beq_datapath dut (
        .clk(clk), .rst(rst), .instruction(instruction), .pc(pc), .ALU_OP(ALU_OP),
        .RegWrite(RegWrite), .wr_reg(wr_reg), .wr_data(wr_data),
        .rd_data1(rd_data1), .rd_data2(rd_data2), .alu_result(alu_result),
        .cout(cout), .slt(slt), .overflow(overflow), .zero_flag(zero_flag),
        .branch_target(branch_target), .branch_taken(branch_taken)
    );

    // Stimulus only: one register write, inputs changed on the falling edge.
    task automatic write_reg(input logic [4:0] r, input logic [31:0] v);
        @(negedge clk);
        RegWrite = 1'b1; wr_reg = r; wr_data = v;
        @(negedge clk);
        RegWrite = 1'b0;
    endtask

    task automatic set_ab(input logic [31:0] a, input logic [31:0] b);
        write_reg(5'd1, a);
        write_reg(5'd2, b);
    endtask

    task automatic test_reset;
        rst = 1'b1; RegWrite = 1'b0; wr_reg = '0; wr_data = '0;
        pc = 32'd1; instruction = 32'h1022_0001; ALU_OP = 4'b0010;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_data1 !== 32'd0 || rd_data2 !== 32'd0) begin
            errors++; $display("FAIL reset_rd: rd1=%h rd2=%h expected 0 0", rd_data1, rd_data2);
        end
        checks++;
        if (alu_result !== 32'd0 || zero_flag !== 1'b1) begin
            errors++; $display("FAIL reset_alu: result=%h zero=%b expected 0 1", alu_result, zero_flag);
        end
        checks++;
        if (branch_target !== 32'd9 || branch_taken !== 1'b0) begin
            errors++; $display("FAIL reset_branch: target=%h taken=%b expected 9 0", branch_target, branch_taken);
        end
        $display("reset: rd1=%h rd2=%h result=%h target=%h", rd_data1, rd_data2, alu_result, branch_target);
    endtask

    task automatic test_beq;
        set_ab(32'd5, 32'd5);
        ALU_OP = 4'b0110;
        #1;
        checks++;
        if (alu_result !== 32'd0 || zero_flag !== 1'b1 || branch_taken !== 1'b1) begin
            errors++; $display("FAIL beq_equal: result=%h zero=%b taken=%b expected 0 1 1", alu_result, zero_flag, branch_taken);
        end
        $display("beq equal: result=%h taken=%b", alu_result, branch_taken);
        instruction = 32'h0022_0001;
        #1;
        checks++;
        if (branch_taken !== 1'b0) begin
            errors++; $display("FAIL beq_opcode: taken=%b expected 0", branch_taken);
        end
        instruction = 32'h1022_0001;
        write_reg(5'd2, 32'd7);
        #1;
        checks++;
        if (alu_result !== 32'hFFFF_FFFE || slt !== 1'b1 || branch_taken !== 1'b0 || cout !== 1'b0) begin
            errors++; $display("FAIL beq_unequal: result=%h slt=%b taken=%b cout=%b expected fffffffe 1 0 0", alu_result, slt, branch_taken, cout);
        end
        $display("beq unequal: result=%h slt=%b taken=%b", alu_result, slt, branch_taken);
        ALU_OP = 4'b0111;
        #1;
        checks++;
        if (alu_result !== 32'd1 || zero_flag !== 1'b0) begin
            errors++; $display("FAIL slt_op: result=%h zero=%b expected 1 0", alu_result, zero_flag);
        end
        $display("slt op: result=%h", alu_result);
    endtask

    task automatic test_branch_target;
        pc = 32'h0000_0100; instruction = 32'h1022_FFFF;
        #1;
        checks++;
        if (branch_target !== 32'h0000_0100) begin
            errors++; $display("FAIL target_neg: target=%h expected 00000100", branch_target);
        end
        $display("target neg: pc=%h target=%h", pc, branch_target);
        pc = 32'hFFFF_FFFC; instruction = 32'h1022_0000;
        #1;
        checks++;
        if (branch_target !== 32'h0000_0000) begin
            errors++; $display("FAIL target_wrap: target=%h expected 00000000", branch_target);
        end
        $display("target wrap: pc=%h target=%h", pc, branch_target);
        pc = 32'h0000_1000; instruction = 32'h1022_8000;
        #1;
        checks++;
        if (branch_target !== 32'hFFFE_1004) begin
            errors++; $display("FAIL target_min: target=%h expected fffe1004", branch_target);
        end
        instruction = 32'h1022_0001;
    endtask

    task automatic test_overflow;
        set_ab(32'h7FFF_FFFF, 32'd1);
        ALU_OP = 4'b0010;
        #1;
        checks++;
        if (alu_result !== 32'h8000_0000 || overflow !== 1'b1 || cout !== 1'b0) begin
            errors++; $display("FAIL add_ovf: result=%h ovf=%b cout=%b expected 80000000 1 0", alu_result, overflow, cout);
        end
        $display("add ovf: result=%h ovf=%b cout=%b", alu_result, overflow, cout);
        set_ab(32'hFFFF_FFFF, 32'd1);
        #1;
        checks++;
        if (alu_result !== 32'd0 || cout !== 1'b1 || zero_flag !== 1'b1 || overflow !== 1'b0) begin
            errors++; $display("FAIL add_carry: result=%h cout=%b zero=%b ovf=%b expected 0 1 1 0", alu_result, cout, zero_flag, overflow);
        end
        $display("add carry: result=%h cout=%b zero=%b", alu_result, cout, zero_flag);
        set_ab(32'h8000_0000, 32'd1);
        ALU_OP = 4'b0110;
        #1;
        checks++;
        if (alu_result !== 32'h7FFF_FFFF || overflow !== 1'b1 || slt !== 1'b1 || cout !== 1'b1) begin
            errors++; $display("FAIL sub_ovf: result=%h ovf=%b slt=%b cout=%b expected 7fffffff 1 1 1", alu_result, overflow, slt, cout);
        end
        $display("sub ovf: result=%h ovf=%b slt=%b", alu_result, overflow, slt);
    endtask

    task automatic test_logic;
        set_ab(32'hF0F0_F0F0, 32'h0FF0_0FF0);
        ALU_OP = 4'b0000;
        #1;
        checks++;
        if (alu_result !== 32'h00F0_00F0 || cout !== 1'b0) begin
            errors++; $display("FAIL and_op: result=%h cout=%b expected 00f000f0 0", alu_result, cout);
        end
        ALU_OP = 4'b0001;
        #1;
        checks++;
        if (alu_result !== 32'hFFF0_FFF0) begin
            errors++; $display("FAIL or_op: result=%h expected fff0fff0", alu_result);
        end
        ALU_OP = 4'b1100;
        #1;
        checks++;
        if (alu_result !== 32'h000F_000F || overflow !== 1'b0) begin
            errors++; $display("FAIL nor_op: result=%h ovf=%b expected 000f000f 0", alu_result, overflow);
        end
        ALU_OP = 4'b1111;
        #1;
        checks++;
        if (alu_result !== 32'd0 || zero_flag !== 1'b1 || cout !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL bad_op: result=%h zero=%b cout=%b ovf=%b expected 0 1 0 0", alu_result, zero_flag, cout, overflow);
        end
        $display("logic: bad op result=%h zero=%b", alu_result, zero_flag);
    endtask

    task automatic test_regfile;
        write_reg(5'd0, 32'h0000_1234);
        instruction = 32'h1000_0000;
        #1;
        checks++;
        if (rd_data1 !== 32'd0 || rd_data2 !== 32'd0) begin
            errors++; $display("FAIL r0_write: rd1=%h rd2=%h expected 0 0", rd_data1, rd_data2);
        end
        $display("r0 write: rd1=%h", rd_data1);
        write_reg(5'd5, 32'h0000_0055);
        @(negedge clk);
        rst = 1'b1; RegWrite = 1'b1; wr_reg = 5'd6; wr_data = 32'hABCD_0000;
        @(negedge clk);
        rst = 1'b0; RegWrite = 1'b0;
        instruction = 32'h10A6_0000;
        #1;
        checks++;
        if (rd_data1 !== 32'd0 || rd_data2 !== 32'd0) begin
            errors++; $display("FAIL rst_write: r5=%h r6=%h expected 0 0", rd_data1, rd_data2);
        end
        $display("reset vs write: r5=%h r6=%h", rd_data1, rd_data2);
    endtask

    task automatic test_back_to_back;
        write_reg(5'd3, 32'h0000_0011);
        instruction = 32'h1060_0000;
        RegWrite = 1'b1; wr_reg = 5'd3; wr_data = 32'h0000_0022;
        #1;
        checks++;
        if (rd_data1 !== 32'h0000_0011) begin
            errors++; $display("FAIL r3_before: rd1=%h expected 00000011", rd_data1);
        end
        @(posedge clk);
        #1;
        RegWrite = 1'b0;
        checks++;
        if (rd_data1 !== 32'h0000_0022) begin
            errors++; $display("FAIL r3_after: rd1=%h expected 00000022", rd_data1);
        end
        $display("r3 write/read: after=%h", rd_data1);
    endtask

    initial begin
        test_reset();
        test_beq();
        test_branch_target();
        test_overflow();
        test_logic();
        test_regfile();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
